// File: rtl/exception_unit.sv
// Exception datapath beside the multicycle control FSM: holds EPC/Cause, latches
// overflow, and fetches the handler address from the vector table with a fixed latency.
module exception_unit #(
    parameter logic [31:0] VEC_BASE   = 32'd254,
    parameter int          MEM_LAT    = 2,
    parameter logic [31:0] EPC_OFFSET = 32'd4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cause_write,
    input  logic        epc_write,
    input  logic        int_cause,
    input  logic [31:0] pc_in,
    input  logic        alu_ovf,
    input  logic        ovf_en,
    input  logic [31:0] mem_data_in,
    input  logic        handler_ack,
    input  logic        rte,
    output logic [31:0] exc_addr,
    output logic [31:0] handler_pc,
    output logic        handler_valid,
    output logic        busy,
    output logic [31:0] epc,
    output logic [31:0] cause,
    output logic        ovf_pending,
    output logic        in_handler,
    output logic        double_fault,
    output logic        lost_exc
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    localparam logic [3:0] LAT = MEM_LAT[3:0];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] exc_addr_q, exc_addr_d;
    logic [31:0] handler_pc_q, handler_pc_d;
    logic        ovf_pending_q, ovf_pending_d;
    logic        in_handler_q, in_handler_d;
    logic        double_fault_q, double_fault_d;
    logic        lost_exc_q, lost_exc_d;

    logic        trigger;
    logic        accept;

    assign trigger = cause_write & epc_write;
    assign accept  = trigger && (state_q == S_IDLE);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        epc_d          = epc_q;
        cause_d        = cause_q;
        exc_addr_d     = exc_addr_q;
        handler_pc_d   = handler_pc_q;
        in_handler_d   = in_handler_q;
        double_fault_d = double_fault_q;
        lost_exc_d     = lost_exc_q;

        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    epc_d      = pc_in - EPC_OFFSET;
                    cause_d    = {31'b0, int_cause};
                    exc_addr_d = VEC_BASE + {31'b0, int_cause};
                    cnt_d      = LAT;
                    if (in_handler_q) begin
                        double_fault_d = 1'b1;
                    end
                    state_d    = S_WAIT;
                end else if (rte) begin
                    in_handler_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (trigger) begin
                    lost_exc_d = 1'b1;
                end
                // <= also catches a zero count so the fetch can never stall
                if (cnt_q <= 4'd1) begin
                    handler_pc_d = {24'b0, mem_data_in[7:0]};
                    cnt_d        = 4'd0;
                    state_d      = S_READY;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_READY: begin
                if (trigger) begin
                    lost_exc_d = 1'b1;
                end
                if (handler_ack) begin
                    in_handler_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // A fresh overflow beats the clear from an accepted overflow exception
    always_comb begin
        ovf_pending_d = ovf_pending_q;
        if (alu_ovf && ovf_en) begin
            ovf_pending_d = 1'b1;
        end else if (accept && int_cause) begin
            ovf_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= 4'd0;
            epc_q          <= 32'd0;
            cause_q        <= 32'd0;
            exc_addr_q     <= 32'd0;
            handler_pc_q   <= 32'd0;
            ovf_pending_q  <= 1'b0;
            in_handler_q   <= 1'b0;
            double_fault_q <= 1'b0;
            lost_exc_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            epc_q          <= epc_d;
            cause_q        <= cause_d;
            exc_addr_q     <= exc_addr_d;
            handler_pc_q   <= handler_pc_d;
            ovf_pending_q  <= ovf_pending_d;
            in_handler_q   <= in_handler_d;
            double_fault_q <= double_fault_d;
            lost_exc_q     <= lost_exc_d;
        end
    end

    assign exc_addr      = exc_addr_q;
    assign handler_pc    = handler_pc_q;
    assign handler_valid = (state_q == S_READY);
    assign busy          = (state_q != S_IDLE);
    assign epc           = epc_q;
    assign cause         = cause_q;
    assign ovf_pending   = ovf_pending_q;
    assign in_handler    = in_handler_q;
    assign double_fault  = double_fault_q;
    assign lost_exc      = lost_exc_q;

endmodule

// File: doc/exception_unit.md
# exception_unit

Exception datapath partner of the multicycle control FSM. It holds EPC and Cause, detects and latches arithmetic overflow for the FSM, and presents the vector-table address. It then fetches the handler address from memory with a fixed read latency and returns it to the FSM via a valid/ack handshake. It also supplies the EPC restore value for RTE.

## Interface
Parameters:
- VEC_BASE, 32'd254, byte address of vector entry for cause 0; cause 1 entry is VEC_BASE+1
- MEM_LAT, 2, rising edges from address presentation to valid memory data; legal range 1..15
- EPC_OFFSET, 32'd4, subtracted from pc_in when capturing EPC

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- cause_write  in  1  exception request (FSM CauseWrite)
- epc_write  in  1  EPC capture enable (FSM EPCWrite); trigger needs both
- int_cause  in  1  0 = nonexistent opcode, 1 = overflow
- pc_in  in  32  current PC (already PC+4)
- alu_ovf  in  1  ALU signed overflow flag
- ovf_en  in  1  high in the ALU-execute cycle of signed ADD/SUB
- mem_data_in  in  32  memory read data; bits [7:0] hold the vector byte
- handler_ack  in  1  FSM loads PC from handler_pc this cycle
- rte  in  1  return-from-exception executing
- exc_addr  out  32  vector-table address for the memory address mux
- handler_pc  out  32  handler address, zero-extended vector byte
- handler_valid  out  1  handler_pc is valid
- busy  out  1  state is WAIT or READY
- epc  out  32  saved return address, also used as the RTE restore value
- cause  out  32  {31'b0, int_cause of last accepted exception}
- ovf_pending  out  1  latched overflow, requests the FSM OVERFLOW path
- in_handler  out  1  the handler is executing
- double_fault  out  1  sticky; an exception was accepted while in_handler=1
- lost_exc  out  1  sticky; a trigger arrived while busy

## Operation
- States: IDLE, WAIT, READY. A 4-bit down-counter cnt is used in WAIT.
- Trigger = cause_write & epc_write.
- IDLE + trigger:
  - epc <= pc_in - EPC_OFFSET (mod 2^32); cause <= {31'b0,int_cause}
  - exc_addr <= VEC_BASE + int_cause; cnt <= MEM_LAT
  - if in_handler, double_fault <= 1
  - go to WAIT
- Trigger with only one of cause_write or epc_write high: ignored, no state change.
- WAIT:
  - if cnt==1: handler_pc <= {24'b0, mem_data_in[7:0]}, go to READY
  - else cnt <= cnt-1
  - exc_addr is held stable throughout
- READY: handler_valid=1. On handler_ack: go to IDLE, in_handler <= 1.
- Trigger in WAIT or READY: ignored, lost_exc <= 1. EPC and Cause are unchanged.
- rte:
  - in IDLE: in_handler <= 0
  - in WAIT or READY: ignored
  - if rte and a trigger coincide in IDLE, the trigger wins and in_handler is unchanged
- ovf_pending:
  - set when alu_ovf & ovf_en
  - cleared by an accepted trigger with int_cause=1
  - if set and clear coincide, set wins
- epc, cause and exc_addr hold their values until the next accepted trigger.
- double_fault and lost_exc clear only on reset.

## Timing
- Reset asserted: state IDLE, cnt 0, every output 0, including exc_addr and handler_pc.
- Reset mid-WAIT or mid-READY aborts the sequence with no partial update.
- Trigger sampled at edge T: epc, cause and exc_addr are valid after T.
- mem_data_in is sampled at edge T+MEM_LAT; handler_valid is high from T+MEM_LAT.
- handler_ack sampled at edge A: handler_valid is low after A and in_handler is high after A.
- ovf_pending is registered and visible one cycle after alu_ovf & ovf_en.
- All outputs are registered except busy and handler_valid, which decode state.

## Test plan
- Nonexistent-opcode path, MEM_LAT=2: pc_in=0x0000_0010, trigger with int_cause=0 -> epc=0x0C, cause=0, exc_addr=254. Memory returns 0x0000_00A0 at T+2 -> handler_valid at T+2, handler_pc=0xA0. Ack -> in_handler=1.
- Overflow path: alu_ovf=1, ovf_en=1 -> ovf_pending=1 next cycle. Trigger with int_cause=1 -> exc_addr=255, ovf_pending=0. Repeat with alu_ovf=1, ovf_en=0 -> ovf_pending stays 0.
- Busy collision: a second trigger during WAIT -> lost_exc=1, epc and cause unchanged, handler_pc from the first request.
- Nested exception: trigger while in_handler=1 -> double_fault=1, epc overwritten. rte in IDLE -> in_handler=0. rte during READY -> ignored.
- Reset mid-WAIT: reset low at T+1 -> all outputs 0 immediately. After release, a fresh trigger completes normally.
- pc_in=0x0000_0002 -> epc=0xFFFF_FFFE (wrap-around). Set/clear collision on ovf_pending -> remains 1.
